// File: rtl/half_duplex_link.sv
// half_duplex_link: device-side controller for a shared tristate data bus.
// Owns bus direction (tx_oe), buffers transmit and receive words in FIFOs,
// inserts a turnaround gap before and after every burst and caps burst length.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-low reset
//   data_io                shared bus, driven only while tx_oe=1
//   tx_oe, tx_stb_o        registered output enable and word strobe
//   peer_oe_i, peer_stb_i  peer drives the bus / peer word valid
//   tx_data_i, tx_push_i   transmit FIFO write side
//   tx_full_o, tx_level_o  transmit FIFO status
//   rx_data_o, rx_valid_o  receive FIFO head (first-word fall-through)
//   rx_pop_i               consume rx_data_o
//   rx_overflow_o          sticky: received word dropped on a full FIFO
//   collision_o            sticky: peer drove the bus while tx_oe=1
//   busy_o                 controller not idle
module half_duplex_link #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TURNAROUND = 2,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    inout  wire  [DATA_W-1:0]           data_io,
    output logic                        tx_oe,
    output logic                        tx_stb_o,
    input  logic                        peer_oe_i,
    input  logic                        peer_stb_i,
    input  logic [DATA_W-1:0]           tx_data_i,
    input  logic                        tx_push_i,
    output logic                        tx_full_o,
    output logic [$clog2(FIFO_DEPTH):0] tx_level_o,
    output logic [DATA_W-1:0]           rx_data_o,
    output logic                        rx_valid_o,
    input  logic                        rx_pop_i,
    output logic                        rx_overflow_o,
    output logic                        collision_o,
    output logic                        busy_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(TURNAROUND + 1);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GAP  = 2'd1;
    localparam logic [1:0] S_TX   = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    // Controller state
    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              tx_oe_q, tx_oe_d;
    logic              tx_stb_q, tx_stb_d;
    logic [DATA_W-1:0] tx_word_q, tx_word_d;
    logic              busy_q, busy_d;
    logic              collision_q, collision_d;

    // Transmit FIFO
    logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
    logic [AW-1:0]     tx_wr_q, tx_wr_d;
    logic [AW-1:0]     tx_rd_q, tx_rd_d;
    logic [LW-1:0]     tx_cnt_q, tx_cnt_d;
    logic              tx_full_q, tx_full_d;
    logic              tx_push_ok;
    logic              tx_pop;

    // Receive FIFO
    logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0]     rx_wr_q, rx_wr_d;
    logic [AW-1:0]     rx_rd_q, rx_rd_d;
    logic [LW-1:0]     rx_cnt_q, rx_cnt_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_overflow_q, rx_overflow_d;
    logic              rx_cap;
    logic              rx_pop_ok;
    logic              rx_wr_ok;

    // Bus driver: word and enable come from the same register edge
    assign data_io = tx_oe_q ? tx_word_q : {DATA_W{1'bz}};

    assign tx_oe         = tx_oe_q;
    assign tx_stb_o      = tx_stb_q;
    assign tx_full_o     = tx_full_q;
    assign tx_level_o    = tx_cnt_q;
    assign rx_data_o     = rx_mem_q[rx_rd_q];
    assign rx_valid_o    = rx_valid_q;
    assign rx_overflow_o = rx_overflow_q;
    assign collision_o   = collision_q;
    assign busy_o        = busy_q;

    // Direction FSM; the next word and enable are decided here so they register together
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        burst_d   = burst_q;
        tx_oe_d   = 1'b0;
        tx_stb_d  = 1'b0;
        tx_word_d = tx_word_q;
        tx_pop    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if ((tx_cnt_q != '0) && !peer_oe_i) begin
                    state_d = S_GAP;
                    cnt_d   = CW'(TURNAROUND);
                end
            end
            S_GAP: begin
                if (peer_oe_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(1)) begin
                    // Last gap cycle: first word goes out with the enable
                    state_d   = S_TX;
                    burst_d   = BW'(1);
                    tx_pop    = 1'b1;
                    tx_oe_d   = 1'b1;
                    tx_stb_d  = 1'b1;
                    tx_word_d = tx_mem_q[tx_rd_q];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_TX: begin
                if (peer_oe_i || (tx_cnt_q == '0) || (burst_q == BW'(MAX_BURST))) begin
                    state_d = S_REL;
                    cnt_d   = CW'(TURNAROUND);
                end else begin
                    burst_d   = burst_q + BW'(1);
                    tx_pop    = 1'b1;
                    tx_oe_d   = 1'b1;
                    tx_stb_d  = 1'b1;
                    tx_word_d = tx_mem_q[tx_rd_q];
                end
            end
            S_REL: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d      = (state_d != S_IDLE);
        collision_d = collision_q | (tx_oe_q & peer_oe_i);
    end

    // FIFO bookkeeping for both directions
    always_comb begin
        tx_push_ok = tx_push_i && !tx_full_q;
        tx_wr_d    = tx_wr_q;
        tx_rd_d    = tx_rd_q;
        if (tx_push_ok) tx_wr_d = tx_wr_q + AW'(1);
        if (tx_pop)     tx_rd_d = tx_rd_q + AW'(1);
        tx_cnt_d  = tx_cnt_q + LW'(tx_push_ok) - LW'(tx_pop);
        tx_full_d = (tx_cnt_d == LW'(FIFO_DEPTH));

        // A pop in the same cycle frees room for a word arriving at a full FIFO
        rx_cap        = peer_oe_i && peer_stb_i && !tx_oe_q;
        rx_pop_ok     = rx_pop_i && (rx_cnt_q != '0);
        rx_wr_ok      = rx_cap && ((rx_cnt_q != LW'(FIFO_DEPTH)) || rx_pop_ok);
        rx_overflow_d = rx_overflow_q | (rx_cap & ~rx_wr_ok);
        rx_wr_d       = rx_wr_q;
        rx_rd_d       = rx_rd_q;
        if (rx_wr_ok)  rx_wr_d = rx_wr_q + AW'(1);
        if (rx_pop_ok) rx_rd_d = rx_rd_q + AW'(1);
        rx_cnt_d   = rx_cnt_q + LW'(rx_wr_ok) - LW'(rx_pop_ok);
        rx_valid_d = (rx_cnt_d != '0);
    end

    // State and status registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            burst_q       <= '0;
            tx_oe_q       <= 1'b0;
            tx_stb_q      <= 1'b0;
            tx_word_q     <= '0;
            busy_q        <= 1'b0;
            collision_q   <= 1'b0;
            tx_wr_q       <= '0;
            tx_rd_q       <= '0;
            tx_cnt_q      <= '0;
            tx_full_q     <= 1'b0;
            rx_wr_q       <= '0;
            rx_rd_q       <= '0;
            rx_cnt_q      <= '0;
            rx_valid_q    <= 1'b0;
            rx_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            burst_q       <= burst_d;
            tx_oe_q       <= tx_oe_d;
            tx_stb_q      <= tx_stb_d;
            tx_word_q     <= tx_word_d;
            busy_q        <= busy_d;
            collision_q   <= collision_d;
            tx_wr_q       <= tx_wr_d;
            tx_rd_q       <= tx_rd_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_full_q     <= tx_full_d;
            rx_wr_q       <= rx_wr_d;
            rx_rd_q       <= rx_rd_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_valid_q    <= rx_valid_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end

    // FIFO storage; contents are don't-care until the pointers cover them
    always_ff @(posedge clk_i) begin
        if (tx_push_ok) tx_mem_q[tx_wr_q] <= tx_data_i;
        if (rx_wr_ok)   rx_mem_q[rx_wr_q] <= data_io;
    end

endmodule

// File: tb/tb_half_duplex_link.sv
// Testbench for half_duplex_link: directed table, hand-written corner
// sequences and random traffic, all checked against a queue-based model.
module tb_half_duplex_link;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TA    = 2;
    localparam int unsigned MB    = 8;

    localparam int P_IDLE = 0;
    localparam int P_GAP  = 1;
    localparam int P_TX   = 2;
    localparam int P_REL  = 3;

    logic          clk;
    logic          rst;
    wire  [DW-1:0] data_io;
    logic          tx_oe, tx_stb, tx_full, rx_valid, rx_ovf, coll, busy;
    logic [4:0]    tx_level;
    logic [DW-1:0] rx_data;
    logic          peer_oe, peer_stb, tx_push, rx_pop;
    logic [DW-1:0] peer_data, tx_data;

    int vec_cnt;
    int miss_cnt;

    // Reference model state
    logic [DW-1:0] m_txq[$];
    logic [DW-1:0] m_rxq[$];
    int            m_phase;
    int            m_timer;
    int            m_sent;
    logic          m_oe, m_stb, m_coll, m_ovf;
    logic [DW-1:0] m_word;

    // Bus observation
    logic [DW-1:0] mon_q[$];
    int            burst_lens[$];
    int            cur_run, idle_run, min_gap;
    logic          seen_burst;
    int            hold;

    typedef struct {
        logic          push;
        logic [DW-1:0] din;
        logic          exp_oe;
        logic          exp_stb;
        logic [DW-1:0] exp_word;
        int            exp_level;
        logic          exp_busy;
    } vec_t;
    vec_t tbl[10];

    // Peer drives the bus only while it owns it and the device has released
    assign data_io = (peer_oe && !tx_oe) ? peer_data : {DW{1'bz}};

    half_duplex_link #(
        .DATA_W    (DW),
        .FIFO_DEPTH(DEPTH),
        .TURNAROUND(TA),
        .MAX_BURST (MB)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_io      (data_io),
        .tx_oe        (tx_oe),
        .tx_stb_o     (tx_stb),
        .peer_oe_i    (peer_oe),
        .peer_stb_i   (peer_stb),
        .tx_data_i    (tx_data),
        .tx_push_i    (tx_push),
        .tx_full_o    (tx_full),
        .tx_level_o   (tx_level),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_pop_i     (rx_pop),
        .rx_overflow_o(rx_ovf),
        .collision_o  (coll),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus cycle of the behavioural model, applied at the rising edge
    task automatic model_step();
        logic push_take;
        if (!rst) begin
            m_txq.delete();
            m_rxq.delete();
            m_phase = P_IDLE;
            m_timer = 0;
            m_sent  = 0;
            m_oe    = 1'b0;
            m_stb   = 1'b0;
            m_coll  = 1'b0;
            m_ovf   = 1'b0;
            return;
        end
        push_take = tx_push && (m_txq.size() < DEPTH);
        if (rx_pop && m_rxq.size() != 0) void'(m_rxq.pop_front());
        if (peer_oe && peer_stb && !m_oe) begin
            if (m_rxq.size() < DEPTH) m_rxq.push_back(peer_data);
            else m_ovf = 1'b1;
        end
        if (m_oe && peer_oe) m_coll = 1'b1;
        m_oe  = 1'b0;
        m_stb = 1'b0;
        case (m_phase)
            P_IDLE: if (m_txq.size() != 0 && !peer_oe) begin
                m_phase = P_GAP;
                m_timer = TA;
            end
            P_GAP: begin
                if (peer_oe) m_phase = P_IDLE;
                else begin
                    m_timer--;
                    if (m_timer == 0) begin
                        m_phase = P_TX;
                        m_word  = m_txq.pop_front();
                        m_sent  = 1;
                        m_oe    = 1'b1;
                        m_stb   = 1'b1;
                    end
                end
            end
            P_TX: begin
                if (peer_oe || m_txq.size() == 0 || m_sent == MB) begin
                    m_phase = P_REL;
                    m_timer = TA;
                end else begin
                    m_word = m_txq.pop_front();
                    m_sent++;
                    m_oe  = 1'b1;
                    m_stb = 1'b1;
                end
            end
            default: begin
                m_timer--;
                if (m_timer == 0) m_phase = P_IDLE;
            end
        endcase
        if (push_take) m_txq.push_back(tx_data);
    endtask

    task automatic check_model();
        chk("m_tx_oe", tx_oe, m_oe);
        chk("m_tx_stb", tx_stb, m_stb);
        if (m_oe) chk("m_tx_word", data_io, m_word);
        if (!m_oe && peer_oe) chk("m_bus_release", data_io, peer_data);
        chk("m_tx_level", tx_level, m_txq.size());
        chk("m_tx_full", tx_full, m_txq.size() == DEPTH);
        chk("m_rx_valid", rx_valid, m_rxq.size() != 0);
        if (m_rxq.size() != 0) chk("m_rx_data", rx_data, m_rxq[0]);
        chk("m_rx_overflow", rx_ovf, m_ovf);
        chk("m_collision", coll, m_coll);
        chk("m_busy", busy, m_phase != P_IDLE);
    endtask

    task automatic reset_stats();
        mon_q.delete();
        burst_lens.delete();
        cur_run    = 0;
        idle_run   = 0;
        min_gap    = 1000;
        seen_burst = 1'b0;
    endtask

    // Advance one cycle: model at the rising edge, checks at the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
        if (tx_stb) begin
            mon_q.push_back(data_io);
            if (cur_run == 0 && seen_burst && idle_run < min_gap) min_gap = idle_run;
            cur_run++;
        end else begin
            if (cur_run != 0) begin
                burst_lens.push_back(cur_run);
                cur_run    = 0;
                seen_burst = 1'b1;
                idle_run   = 0;
            end
            if (!tx_oe) idle_run++;
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int t = 0; t < limit; t++) begin
            if (tx_level == 0 && !busy) break;
            tick();
        end
        chk({name, "_drained_busy"}, busy, 1'b0);
        chk({name, "_drained_level"}, tx_level, 0);
    endtask

    initial begin
        vec_cnt  = 0;
        miss_cnt = 0;
        rst = 1'b0; peer_oe = 1'b0; peer_stb = 1'b0; peer_data = '0;
        tx_push = 1'b0; tx_data = '0; rx_pop = 1'b0;
        m_phase = P_IDLE; m_timer = 0; m_sent = 0; m_word = '0;
        m_oe = 1'b0; m_stb = 1'b0; m_coll = 1'b0; m_ovf = 1'b0;
        reset_stats();

        // push, din, oe, stb, word, level, busy
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 2, 1'b1};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 3, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 2, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 0, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0};

        // Reset held two cycles with pushes active
        tx_push = 1'b1; tx_data = 8'hAA;
        tick();
        tick();
        chk("rst_tx_oe", tx_oe, 1'b0);
        chk("rst_tx_stb", tx_stb, 1'b0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_tx_full", tx_full, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_overflow", rx_ovf, 1'b0);
        chk("rst_collision", coll, 1'b0);
        chk("rst_busy", busy, 1'b0);
        tx_push = 1'b0;
        rst = 1'b1;
        tick();

        // Single burst from the table
        reset_stats();
        for (int i = 0; i < 10; i++) begin
            tx_push = tbl[i].push;
            tx_data = tbl[i].din;
            tick();
            chk($sformatf("tbl%0d_oe", i), tx_oe, tbl[i].exp_oe);
            chk($sformatf("tbl%0d_stb", i), tx_stb, tbl[i].exp_stb);
            if (tbl[i].exp_stb) chk($sformatf("tbl%0d_word", i), data_io, tbl[i].exp_word);
            chk($sformatf("tbl%0d_level", i), tx_level, tbl[i].exp_level);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
        end

        // Burst limit: 20 words split 8/8/4 with turnaround windows between
        reset_stats();
        for (int i = 0; i < 20; i++) begin
            tx_push = 1'b1;
            tx_data = 8'(8'h40 + i);
            tick();
        end
        tx_push = 1'b0;
        wait_drain("burst", 200);
        tick();
        chk("burst_count", burst_lens.size(), 3);
        if (burst_lens.size() == 3) begin
            chk("burst0_len", burst_lens[0], 8);
            chk("burst1_len", burst_lens[1], 8);
            chk("burst2_len", burst_lens[2], 4);
        end
        chk("burst_gap_ge4", min_gap >= 2 * TA, 1'b1);
        chk("burst_words", mon_q.size(), 20);
        for (int i = 0; i < mon_q.size() && i < 20; i++)
            chk($sformatf("burst_word%0d", i), mon_q[i], 8'(8'h40 + i));

        // Collision in the 2nd TX cycle of a 5-word burst
        reset_stats();
        for (int i = 0; i < 5; i++) begin
            tx_push = 1'b1;
            tx_data = 8'(8'h60 + i);
            tick();
        end
        tx_push = 1'b0;
        chk("coll_pre_stb", tx_stb, 1'b1);
        peer_oe = 1'b1; peer_data = 8'h5A;
        tick();
        chk("coll_flag", coll, 1'b1);
        chk("coll_oe_drop", tx_oe, 1'b0);
        chk("coll_level", tx_level, 3);
        chk("coll_sent", mon_q.size(), 2);
        for (int i = 0; i < 4; i++) tick();
        chk("coll_hold_off", tx_oe, 1'b0);
        peer_oe = 1'b0;
        wait_drain("coll", 60);
        chk("coll_resumed", mon_q.size(), 5);
        for (int i = 0; i < mon_q.size() && i < 5; i++)
            chk($sformatf("coll_word%0d", i), mon_q[i], 8'(8'h60 + i));
        chk("coll_sticky", coll, 1'b1);

        // RX overflow: 17 strobed words, no pops
        peer_oe = 1'b1; peer_stb = 1'b1;
        for (int i = 0; i < 17; i++) begin
            peer_data = 8'(i);
            tick();
        end
        peer_oe = 1'b0; peer_stb = 1'b0;
        tick();
        chk("ovf_flag", rx_ovf, 1'b1);
        chk("ovf_valid", rx_valid, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_pop%0d", i), rx_data, 8'(i));
            rx_pop = 1'b1;
            tick();
        end
        chk("ovf_empty", rx_valid, 1'b0);
        tick();
        rx_pop = 1'b0;
        chk("ovf_pop_empty", rx_valid, 1'b0);
        chk("ovf_sticky", rx_ovf, 1'b1);

        // Full FIFO, ignored push, push during a TX pop cycle
        reset_stats();
        peer_oe = 1'b1; peer_data = 8'hC3;
        for (int i = 0; i < 16; i++) begin
            tx_push = 1'b1;
            tx_data = 8'(8'h80 + i);
            tick();
        end
        chk("full_level", tx_level, 16);
        chk("full_flag", tx_full, 1'b1);
        tx_data = 8'hFF;
        tick();
        chk("full_ignored", tx_level, 16);
        tx_push = 1'b0;
        peer_oe = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (tx_stb) break;
            tick();
        end
        chk("full_first_stb", tx_stb, 1'b1);
        chk("full_first_level", tx_level, 15);
        tx_push = 1'b1; tx_data = 8'hEE;
        tick();
        tx_push = 1'b0;
        chk("simul_level", tx_level, 15);
        wait_drain("full", 200);
        chk("full_words", mon_q.size(), 17);
        for (int i = 0; i < mon_q.size() && i < 17; i++)
            chk($sformatf("full_word%0d", i), mon_q[i], (i < 16) ? 8'(8'h80 + i) : 8'hEE);

        // Random traffic with a mid-run reset
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                peer_oe = !peer_oe;
                hold = peer_oe ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 25));
            end
            hold--;
            peer_stb  = peer_oe & ($urandom_range(0, 1) == 1);
            peer_data = 8'($urandom);
            tx_push   = ($urandom_range(0, 2) == 0);
            tx_data   = 8'($urandom);
            rx_pop    = ($urandom_range(0, 3) == 0);
            rst       = (c != 1500);
            tick();
        end
        rst = 1'b1; peer_oe = 1'b0; peer_stb = 1'b0; tx_push = 1'b0; rx_pop = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/half_duplex_link.md
# half_duplex_link

Parametrised device-side controller for a shared, bidirectional tristate data bus. It owns direction control (`tx_oe`) and buffers traffic in both directions with on-chip FIFOs. It enforces a turnaround gap before and after every transmit burst, and bounds burst length so the peer can regain the bus. It sits between the bus pins and the device's memory/protocol logic, replacing a hard-wired single-line, externally-driven `tx_oe` scheme.

## Interface
- `DATA_W`, 8, bus and FIFO word width (≥1)
- `FIFO_DEPTH`, 16, entries per FIFO (power of 2, ≥2)
- `TURNAROUND`, 2, idle cycles with bus released before and after a burst (≥1)
- `MAX_BURST`, 8, maximum words per transmit burst (≥1)

Ports:
- `clk_i` in 1: single clock, all logic rising-edge
- `rst_i` in 1: synchronous, active-low reset
- `data_io` inout `DATA_W`: shared bus. Driven with the tx word when `tx_oe`=1, else high-Z.
- `tx_oe` out 1: output enable, registered
- `tx_stb_o` out 1: word on `data_io` is valid this cycle
- `peer_oe_i` in 1: peer is driving the bus
- `peer_stb_i` in 1: peer word on `data_io` is valid
- `tx_data_i` in `DATA_W`: word to transmit
- `tx_push_i` in 1: write `tx_data_i` into the tx FIFO
- `tx_full_o` out 1: tx FIFO full
- `tx_level_o` out `$clog2(FIFO_DEPTH)+1`: tx FIFO occupancy
- `rx_data_o` out `DATA_W`: head of the rx FIFO (first-word fall-through)
- `rx_valid_o` out 1: rx FIFO non-empty
- `rx_pop_i` in 1: consume `rx_data_o`
- `rx_overflow_o` out 1: sticky, a received word was dropped
- `collision_o` out 1: sticky, `peer_oe_i` seen while `tx_oe`=1
- `busy_o` out 1: FSM not in IDLE

## Operation
- **Reset** (`rst_i`=0 at an edge):
  - FSM goes to IDLE.
  - Both FIFOs are emptied.
  - `tx_oe`, `tx_stb_o`, `tx_full_o`, `rx_valid_o`, `rx_overflow_o`, `collision_o`, `busy_o` are 0; `tx_level_o` is 0.
  - `data_io` is high-Z.
  - A reset mid-burst drops `tx_oe` at that edge and discards queued words.
- **TX FIFO**:
  - A push is accepted only when `tx_full_o`=0. A push while full is ignored with no flag.
  - An internal pop on the same cycle as a push is legal.
  - Level changes by +1/−1/0 accordingly.
- **RX capture**:
  - Capture `data_io` when `peer_oe_i`=1, `peer_stb_i`=1 and `tx_oe`=0.
  - If the rx FIFO is full, the word is dropped and `rx_overflow_o` is set. It is not set if `rx_pop_i` frees a slot in the same cycle.
  - `rx_pop_i` while empty is ignored.
- **FSM**:
  - **IDLE**: if the tx FIFO is non-empty and `peer_oe_i`=0, go to GAP and load the counter with `TURNAROUND`.
  - **GAP**: `tx_oe`=0; decrement the counter each cycle.
    - If `peer_oe_i`=1, go back to IDLE (abort).
    - When the counter reaches 0 after `TURNAROUND` cycles, go to TX and clear the burst counter.
  - **TX**: `tx_oe`=1. Each cycle the FIFO is non-empty, drive the head word, assert `tx_stb_o`, pop, and increment the burst count.
    - Go to RELEASE when the FIFO empties, when `MAX_BURST` words have been sent, or when `peer_oe_i`=1.
    - `peer_oe_i`=1 also sets `collision_o`; the word in flight that cycle still completes.
  - **RELEASE**: `tx_oe`=0 for `TURNAROUND` cycles, then go to IDLE.
    - If data remains, the next burst then needs a fresh GAP, so the peer gets at least 2×`TURNAROUND` cycles of window.
- **Sticky flags**: cleared only by reset.

## Timing
- `tx_oe`, `tx_stb_o` and the driven word are registered and change together on the same edge. No combinational path from `peer_oe_i` to `tx_oe`.
- **Push to bus**, with no contention: push sampled at edge E makes the FIFO non-empty after E.
  - IDLE→GAP at E+1.
  - First `tx_stb_o`/`tx_oe`=1 in the cycle after edge E+1+`TURNAROUND`.
  - With defaults, the first word appears 3 cycles after the push edge.
- **Burst**: words are back-to-back, one per cycle, with no bubbles while data is available.
- **RX**: word captured at edge E gives `rx_valid_o`=1 and `rx_data_o` valid from E. Pop at edge E+k presents the next word from E+k.
- `busy_o`=1 in GAP, TX and RELEASE.

## Test plan
- **Reset**: hold `rst_i`=0 for 2 cycles with pushes active → all outputs 0, `data_io` high-Z, `tx_level_o`=0.
- **Single burst**: push 0x11, 0x22, 0x33 on consecutive cycles with the peer idle → after a 2-cycle gap, `tx_stb_o` high for exactly 3 cycles carrying 0x11, 0x22, 0x33; then `tx_oe` low for 2 cycles; then IDLE.
- **Burst limit**: push 20 words → bursts of 8, 8, 4. Each pair of bursts is separated by ≥4 cycles with `tx_oe`=0.
- **Collision**: raise `peer_oe_i` in the 2nd TX cycle of a 5-word burst → `collision_o`=1, `tx_oe` drops next edge, 3 words remain (`tx_level_o`=3). Transmission resumes after the peer releases.
- **RX overflow**: peer strobes 17 words (0x00–0x10) with no pops → `rx_overflow_o`=1; popping returns 0x00–0x0F and 0x10 is absent.
- **Full/simultaneous**: fill the tx FIFO to 16, push once more → ignored, `tx_level_o` stays 16. Push during a TX pop cycle → level unchanged and the word is later sent in order.
